rs_src_trk: RTL and testbench

- Per-entry, multi-source operand tracker for a reservation-station entry.
- Tracks NUM_SRCS physical sources, each with its own wakeup state machine, against NUM_WR integer PRF writeback ports.
- Optionally captures the writeback data, so the entry can issue without a PRF read of woken sources.
- Produces per-source ready, entry-level all-ready and captured operand data for the RS picker and issue mux.

---
 rtl/rs_pkg.sv | 39 +++
 rtl/rs_src_slot.sv | 111 +++++++++++
 rtl/rs_src_trk.sv | 84 ++++++++
 tb/tb_rs_src_trk.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared types for reservation-station operand tracking: static source info,
// PRF writeback packets and the per-source wakeup state encoding.
package rs_pkg;
    localparam int RS_MAX_SRCS     = 4;
    localparam int IPRF_NUM_WRITES = 2;
    localparam int PRF_ID_W        = 7;
    localparam int XLEN            = 64;

    typedef logic [PRF_ID_W-1:0] t_prf_id;
    typedef logic [XLEN-1:0]     t_rv_reg_data;

    typedef enum logic [1:0] {
        OP_REG  = 2'd0,
        OP_IMM  = 2'd1,
        OP_PC   = 2'd2,
        OP_ZERO = 2'd3
    } t_src_optype;

    typedef struct packed {
        t_src_optype optype;
    } t_src_descr;

    typedef struct packed {
        logic       psrc_pend;
        t_prf_id    psrc;
        t_src_descr descr;
    } t_rs_src_static;

    typedef struct packed {
        t_prf_id      pdst;
        t_rv_reg_data data;
    } t_prf_wr_pkt;

    typedef enum logic [1:0] {
        SRC_IDLE     = 2'd0,
        SRC_PDG_RSLT = 2'd1,
        SRC_READY    = 2'd2
    } t_src_fsm;
endpackage

// File: rtl/rs_src_slot.sv
// One source operand: writeback snoop, wakeup FSM and optional data capture,
// with a same-cycle bypass of the matching writeback to the outputs.
module rs_src_slot
    import rs_pkg::*;
#(
    parameter int NUM_WR       = IPRF_NUM_WRITES,
    parameter bit CAPTURE_DATA = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               alloc,
    input  logic               dealloc,
    input  logic               flush,
    input  logic               psrc_pend,
    input  t_prf_id            psrc,
    input  logic [NUM_WR-1:0]  wr_en,
    input  t_prf_wr_pkt        wr_pkt [NUM_WR],
    output t_src_fsm           state,
    output logic               src_ready,
    output logic               src_data_vld,
    output t_rv_reg_data       src_data
);
    t_src_fsm           state_q;
    t_src_fsm           state_nxt;
    logic [NUM_WR-1:0]  match_vec;
    logic               match;
    logic               kill;
    logic               capture;
    logic               wake_bypass;
    t_rv_reg_data       wr_data_mux;

    // Ports are one-hot per source, so an AND-OR mux is sufficient.
    always_comb begin
        match_vec   = '0;
        wr_data_mux = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            match_vec[p] = wr_en[p] && (wr_pkt[p].pdst == psrc);
            wr_data_mux  = wr_data_mux | ({XLEN{match_vec[p]}} & wr_pkt[p].data);
        end
    end

    assign match = |match_vec;
    assign kill  = flush | dealloc;

    always_comb begin
        state_nxt = state_q;
        capture   = 1'b0;
        case (state_q)
            SRC_IDLE: begin
                if (alloc) begin
                    if (!psrc_pend) begin
                        state_nxt = SRC_READY;
                    end else if (match) begin
                        state_nxt = SRC_READY;
                        capture   = 1'b1;
                    end else begin
                        state_nxt = SRC_PDG_RSLT;
                    end
                end
            end
            SRC_PDG_RSLT: begin
                if (match) begin
                    state_nxt = SRC_READY;
                    capture   = 1'b1;
                end
            end
            default: ;
        endcase
        // Flush/dealloc drop any wakeup arriving in the same cycle.
        if (kill) begin
            state_nxt = SRC_IDLE;
            capture   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= SRC_IDLE;
        else       state_q <= state_nxt;
    end

    assign state       = state_q;
    assign wake_bypass = (state_q == SRC_PDG_RSLT) && match;
    assign src_ready   = (state_q == SRC_READY) || wake_bypass;

    generate
        if (CAPTURE_DATA) begin : g_cap
            logic         data_vld_q;
            t_rv_reg_data data_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    data_vld_q <= 1'b0;
                    data_q     <= '0;
                end else if (kill) begin
                    data_vld_q <= 1'b0;
                end else if (capture) begin
                    data_vld_q <= 1'b1;
                    data_q     <= wr_data_mux;
                end
            end

            assign src_data_vld = wake_bypass || data_vld_q;
            assign src_data     = wake_bypass ? wr_data_mux : data_q;
        end else begin : g_nocap
            assign src_data_vld = 1'b0;
            assign src_data     = '0;
        end
    endgenerate

    a_one_port_match: assert property (@(posedge clk) disable iff (reset) $onehot0(match_vec));
endmodule

// File: rtl/rs_src_trk.sv
// Reservation-station entry operand tracker: latches per-source static info on
// allocation and reduces the per-source wakeup slots into an entry ready.
module rs_src_trk
    import rs_pkg::*;
#(
    parameter int NUM_SRCS     = 3,
    parameter int NUM_WR       = IPRF_NUM_WRITES,
    parameter bit CAPTURE_DATA = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               e_alloc_rs0,
    input  t_rs_src_static     e_alloc_static_rs0 [NUM_SRCS],
    output t_rs_src_static     e_static [NUM_SRCS],
    input  logic               e_dealloc,
    input  logic               e_flush,
    input  logic [NUM_WR-1:0]  iprf_wr_en_ro0,
    input  t_prf_wr_pkt        iprf_wr_pkt_ro0 [NUM_WR],
    output logic [NUM_SRCS-1:0] src_ready_rs1,
    output logic [NUM_SRCS-1:0] src_data_vld_rs1,
    output t_rv_reg_data       src_data_rs1 [NUM_SRCS],
    output logic               ready_rs1
);
    t_rs_src_static      e_static_q   [NUM_SRCS];
    t_rs_src_static      e_static_nxt [NUM_SRCS];
    t_src_fsm            src_state    [NUM_SRCS];
    logic [NUM_SRCS-1:0] busy;
    logic [NUM_SRCS-1:0] bad_pend;

    // The alloc cycle must snoop against the incoming psrc, not the stale copy.
    always_comb begin
        for (int s = 0; s < NUM_SRCS; s++) begin
            e_static_nxt[s] = e_alloc_rs0 ? e_alloc_static_rs0[s] : e_static_q[s];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_SRCS; s++) e_static_q[s] <= '0;
        end else begin
            e_static_q <= e_static_nxt;
        end
    end

    assign e_static = e_static_q;

    generate
        for (genvar s = 0; s < NUM_SRCS; s++) begin : g_src
            rs_src_slot #(
                .NUM_WR       (NUM_WR),
                .CAPTURE_DATA (CAPTURE_DATA)
            ) u_slot (
                .clk          (clk),
                .reset        (reset),
                .alloc        (e_alloc_rs0),
                .dealloc      (e_dealloc),
                .flush        (e_flush),
                .psrc_pend    (e_static_nxt[s].psrc_pend),
                .psrc         (e_static_nxt[s].psrc),
                .wr_en        (iprf_wr_en_ro0),
                .wr_pkt       (iprf_wr_pkt_ro0),
                .state        (src_state[s]),
                .src_ready    (src_ready_rs1[s]),
                .src_data_vld (src_data_vld_rs1[s]),
                .src_data     (src_data_rs1[s])
            );
        end
    endgenerate

    always_comb begin
        for (int s = 0; s < NUM_SRCS; s++) begin
            busy[s]     = (src_state[s] != SRC_IDLE);
            bad_pend[s] = e_alloc_rs0 && e_alloc_static_rs0[s].psrc_pend
                          && (e_alloc_static_rs0[s].descr.optype != OP_REG);
        end
    end

    // An unallocated entry has every slot idle, which keeps ready_rs1 low.
    assign ready_rs1 = (|busy) && (&src_ready_rs1);

    a_alloc_while_busy: assert property (@(posedge clk) disable iff (reset) !(e_alloc_rs0 && (|busy)));
    a_alloc_dealloc:    assert property (@(posedge clk) disable iff (reset) !(e_alloc_rs0 && e_dealloc));
    a_pend_non_reg:     assert property (@(posedge clk) disable iff (reset) (bad_pend == '0));
endmodule

// File: tb/tb_rs_src_trk.sv
// Table-driven bench for rs_src_trk: one row per cycle, expected outputs go
// through a scoreboard queue and are compared mid-cycle.
module tb_rs_src_trk;
    import rs_pkg::*;

    localparam int NS = 3;
    localparam int NW = IPRF_NUM_WRITES;

    logic           clk = 1'b0;
    logic           reset;
    logic           e_alloc_rs0;
    t_rs_src_static e_alloc_static_rs0 [NS];
    t_rs_src_static e_static [NS];
    logic           e_dealloc;
    logic           e_flush;
    logic [NW-1:0]  iprf_wr_en_ro0;
    t_prf_wr_pkt    iprf_wr_pkt_ro0 [NW];
    logic [NS-1:0]  src_ready_rs1;
    logic [NS-1:0]  src_data_vld_rs1;
    t_rv_reg_data   src_data_rs1 [NS];
    logic           ready_rs1;

    always #5 clk = ~clk;

    rs_src_trk #(.NUM_SRCS(NS), .NUM_WR(NW), .CAPTURE_DATA(1'b1)) dut (
        .clk                (clk),
        .reset              (reset),
        .e_alloc_rs0        (e_alloc_rs0),
        .e_alloc_static_rs0 (e_alloc_static_rs0),
        .e_static           (e_static),
        .e_dealloc          (e_dealloc),
        .e_flush            (e_flush),
        .iprf_wr_en_ro0     (iprf_wr_en_ro0),
        .iprf_wr_pkt_ro0    (iprf_wr_pkt_ro0),
        .src_ready_rs1      (src_ready_rs1),
        .src_data_vld_rs1   (src_data_vld_rs1),
        .src_data_rs1       (src_data_rs1),
        .ready_rs1          (ready_rs1)
    );

    typedef struct packed {
        logic            rst;
        logic            alloc;
        logic            dealloc;
        logic            flush;
        logic [2:0]      pend;
        logic [2:0][6:0] psrc;
        logic [1:0]      wr_en;
        logic [1:0][6:0] pdst;
        logic [1:0][63:0] wdata;
        logic [2:0]      exp_rdy;
        logic            exp_all;
        logic [2:0]      exp_vld;
        logic [2:0][63:0] exp_data;
        logic            exp_zero;
    } vec_t;

    typedef struct packed {
        logic [2:0]       rdy;
        logic             all;
        logic [2:0]       vld;
        logic [2:0][63:0] data;
        logic             zero;
        logic [2:0][6:0]  psrc;
        logic [2:0]       pend;
    } exp_t;

    vec_t tbl [$];
    exp_t sb  [$];
    int   n_checks = 0;
    int   n_err    = 0;
    logic [2:0][6:0] m_psrc;
    logic [2:0]      m_pend;

    function automatic vec_t v(input logic rst, alloc, dealloc, flush, input logic [2:0] pend,
                               input logic [6:0] p0, p1, p2,
                               input logic e0, input logic [6:0] d0, input logic [63:0] w0,
                               input logic e1, input logic [6:0] d1, input logic [63:0] w1,
                               input logic [2:0] rdy, input logic all, input logic [2:0] vld,
                               input logic [63:0] x0, x1, x2, input logic zero);
        vec_t r;
        r.rst = rst; r.alloc = alloc; r.dealloc = dealloc; r.flush = flush; r.pend = pend;
        r.psrc[0] = p0; r.psrc[1] = p1; r.psrc[2] = p2;
        r.wr_en = {e1, e0}; r.pdst[0] = d0; r.pdst[1] = d1; r.wdata[0] = w0; r.wdata[1] = w1;
        r.exp_rdy = rdy; r.exp_all = all; r.exp_vld = vld;
        r.exp_data[0] = x0; r.exp_data[1] = x1; r.exp_data[2] = x2; r.exp_zero = zero;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t r);
        exp_t e;
        exp_t g;
        @(negedge clk);
        reset       = r.rst;
        e_alloc_rs0 = r.alloc;
        e_dealloc   = r.dealloc;
        e_flush     = r.flush;
        for (int s = 0; s < NS; s++) begin
            e_alloc_static_rs0[s].psrc_pend    = r.pend[s];
            e_alloc_static_rs0[s].psrc         = r.psrc[s];
            e_alloc_static_rs0[s].descr.optype = OP_REG;
        end
        iprf_wr_en_ro0 = r.wr_en;
        for (int p = 0; p < NW; p++) begin
            iprf_wr_pkt_ro0[p].pdst = r.pdst[p];
            iprf_wr_pkt_ro0[p].data = r.wdata[p];
        end
        e.rdy = r.exp_rdy; e.all = r.exp_all; e.vld = r.exp_vld;
        e.data = r.exp_data; e.zero = r.exp_zero; e.psrc = m_psrc; e.pend = m_pend;
        sb.push_back(e);
        #2;
        g = sb.pop_front();
        chk($sformatf("row%0d src_ready", idx), 64'(src_ready_rs1), 64'(g.rdy));
        chk($sformatf("row%0d ready_rs1", idx), 64'(ready_rs1), 64'(g.all));
        chk($sformatf("row%0d data_vld", idx), 64'(src_data_vld_rs1), 64'(g.vld));
        for (int s = 0; s < NS; s++) begin
            if (g.vld[s] || g.zero)
                chk($sformatf("row%0d data%0d", idx, s), src_data_rs1[s], g.data[s]);
            chk($sformatf("row%0d static_psrc%0d", idx, s), 64'(e_static[s].psrc), 64'(g.psrc[s]));
            chk($sformatf("row%0d static_pend%0d", idx, s), 64'(e_static[s].psrc_pend), 64'(g.pend[s]));
        end
        if (r.rst) begin
            m_psrc = '0;
            m_pend = '0;
        end else if (r.alloc) begin
            m_psrc = r.psrc;
            m_pend = r.pend;
        end
    endtask

    initial begin
        reset = 1'b1; e_alloc_rs0 = 1'b0; e_dealloc = 1'b0; e_flush = 1'b0; iprf_wr_en_ro0 = '0;
        for (int s = 0; s < NS; s++) e_alloc_static_rs0[s] = '0;
        for (int p = 0; p < NW; p++) iprf_wr_pkt_ro0[p] = '0;
        m_psrc = '0;
        m_pend = '0;
        repeat (3) @(posedge clk);

        // all sources non-pending
        tbl.push_back(v(0,0,0,0,3'b000, 0,0,0,   0,0,0, 0,0,0, 3'b000,0,3'b000, 0,0,0, 1));
        tbl.push_back(v(0,1,0,0,3'b000, 1,2,3,   0,0,0, 0,0,0, 3'b000,0,3'b000, 0,0,0, 0));
        tbl.push_back(v(0,0,0,0,3'b000, 0,0,0,   0,0,0, 0,0,0, 3'b111,1,3'b000, 0,0,0, 0));
        tbl.push_back(v(0,0,1,0,3'b000, 0,0,0,   0,0,0, 0,0,0, 3'b111,1,3'b000, 0,0,0, 0));
        tbl.push_back(v(0,0,0,0,3'b000, 0,0,0,   0,0,0, 0,0,0, 3'b000,0,3'b000, 0,0,0, 0));
        // src0 waits on psrc 12, woken later on port 1
        tbl.push_back(v(0,1,0,0,3'b001, 12,2,3,  0,0,0, 0,0,0, 3'b000,0,3'b000, 0,0,0, 0));
        tbl.push_back(v(0,0,0,0,3'b000, 0,0,0,   0,0,0, 0,0,0, 3'b110,0,3'b000, 0,0,0, 0));
        tbl.push_back(v(0,0,0,0,3'b000, 0,0,0,   1,13,64'h1313, 0,0,0, 3'b110,0,3'b000, 0,0,0, 0));
        tbl.push_back(v(0,0,0,0,3'b000, 0,0,0,   0,0,0, 0,0,0, 3'b110,0,3'b000, 0,0,0, 0));
        tbl.push_back(v(0,0,0,0,3'b000, 0,0,0,   0,0,0, 1,12,64'hDEAD, 3'b111,1,3'b001, 64'hDEAD,0,0, 0));
        tbl.push_back(v(0,0,0,0,3'b000, 0,0,0,   1,12,64'hBEEF, 0,0,0, 3'b111,1,3'b001, 64'hDEAD,0,0, 0));
        tbl.push_back(v(0,0,0,0,3'b000, 0,0,0,   0,0,0, 0,0,0, 3'b111,1,3'b001, 64'hDEAD,0,0, 0));
        tbl.push_back(v(0,0,1,0,3'b000, 0,0,0,   0,0,0, 0,0,0, 3'b111,1,3'b001, 64'hDEAD,0,0, 0));
        tbl.push_back(v(0,0,0,0,3'b000, 0,0,0,   0,0,0, 0,0,0, 3'b000,0,3'b000, 0,0,0, 0));
        // src1 woken in its alloc cycle
        tbl.push_back(v(0,1,0,0,3'b010, 1,7,3,   1,7,64'h7777, 0,0,0, 3'b000,0,3'b000, 0,0,0, 0));
        tbl.push_back(v(0,0,0,0,3'b000, 0,0,0,   0,0,0, 0,0,0, 3'b111,1,3'b010, 0,64'h7777,0, 0));
        tbl.push_back(v(0,0,1,0,3'b000, 0,0,0,   0,0,0, 0,0,0, 3'b111,1,3'b010, 0,64'h7777,0, 0));
        tbl.push_back(v(0,0,0,0,3'b000, 0,0,0,   0,0,0, 0,0,0, 3'b000,0,3'b000, 0,0,0, 0));
        // two sources woken together on both ports
        tbl.push_back(v(0,1,0,0,3'b011, 5,9,3,   0,0,0, 0,0,0, 3'b000,0,3'b000, 0,0,0, 0));
        tbl.push_back(v(0,0,0,0,3'b000, 0,0,0,   0,0,0, 0,0,0, 3'b100,0,3'b000, 0,0,0, 0));
        tbl.push_back(v(0,0,0,0,3'b000, 0,0,0,   1,5,64'h55, 1,9,64'h99, 3'b111,1,3'b011, 64'h55,64'h99,0, 0));
        tbl.push_back(v(0,0,0,0,3'b000, 0,0,0,   0,0,0, 0,0,0, 3'b111,1,3'b011, 64'h55,64'h99,0, 0));
        tbl.push_back(v(0,0,1,0,3'b000, 0,0,0,   0,0,0, 0,0,0, 3'b111,1,3'b011, 64'h55,64'h99,0, 0));
        tbl.push_back(v(0,0,0,0,3'b000, 0,0,0,   0,0,0, 0,0,0, 3'b000,0,3'b000, 0,0,0, 0));
        // flush against a concurrent wakeup, then re-alloc
        tbl.push_back(v(0,1,0,0,3'b001, 20,2,3,  0,0,0, 0,0,0, 3'b000,0,3'b000, 0,0,0, 0));
        tbl.push_back(v(0,0,0,0,3'b000, 0,0,0,   0,0,0, 0,0,0, 3'b110,0,3'b000, 0,0,0, 0));
        tbl.push_back(v(0,0,0,1,3'b000, 0,0,0,   1,20,64'hAAAA, 0,0,0, 3'b111,1,3'b001, 64'hAAAA,0,0, 0));
        tbl.push_back(v(0,0,0,0,3'b000, 0,0,0,   0,0,0, 0,0,0, 3'b000,0,3'b000, 0,0,0, 0));
        tbl.push_back(v(0,1,0,0,3'b000, 20,2,3,  0,0,0, 0,0,0, 3'b000,0,3'b000, 0,0,0, 0));
        tbl.push_back(v(0,0,0,0,3'b000, 0,0,0,   0,0,0, 0,0,0, 3'b111,1,3'b000, 0,0,0, 0));
        tbl.push_back(v(0,0,1,0,3'b000, 0,0,0,   0,0,0, 0,0,0, 3'b111,1,3'b000, 0,0,0, 0));
        tbl.push_back(v(0,0,0,0,3'b000, 0,0,0,   0,0,0, 0,0,0, 3'b000,0,3'b000, 0,0,0, 0));

        for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

        // reset while src2 is pending, with its writeback in the same cycle
        apply(100, v(0,1,0,0,3'b100, 1,2,33, 0,0,0, 0,0,0, 3'b000,0,3'b000, 0,0,0, 0));
        apply(101, v(0,0,0,0,3'b000, 0,0,0,  0,0,0, 0,0,0, 3'b011,0,3'b000, 0,0,0, 0));
        apply(102, v(1,0,0,0,3'b000, 0,0,0,  0,0,0, 1,33,64'h3333, 3'b111,1,3'b100, 0,0,64'h3333, 0));
        apply(103, v(0,0,0,0,3'b000, 0,0,0,  0,0,0, 0,0,0, 3'b000,0,3'b000, 0,0,0, 1));
        apply(104, v(0,0,0,0,3'b000, 0,0,0,  0,0,0, 1,33,64'h3333, 3'b000,0,3'b000, 0,0,0, 1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
